// File: rtl/multicycle_alu_pkg.sv
// rtl/multicycle_alu_pkg.sv - opcode and state encodings shared by the multicycle ALU
package multicycle_alu_pkg;

    typedef enum logic [3:0] {
        OP_SUB  = 4'b0001,
        OP_AND  = 4'b0010,
        OP_OR   = 4'b0011,
        OP_NEG  = 4'b0100,
        OP_NOT  = 4'b0101,
        OP_SHR  = 4'b0110,
        OP_SHRA = 4'b0111,
        OP_SHL  = 4'b1000,
        OP_ROR  = 4'b1001,
        OP_ROL  = 4'b1010,
        OP_MUL  = 4'b1011,
        OP_DIV  = 4'b1100,
        OP_ADD  = 4'b1101
    } opcode_e;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_MUL,
        ST_DIV,
        ST_DONE
    } state_e;

endpackage

// File: rtl/seq_divider.sv
// rtl/seq_divider.sv - signed restoring divider, one quotient bit per cycle
module seq_divider #(
    parameter int WIDTH = 32
) (
    input  logic             clk_i,
    input  logic             rst_ni,
    input  logic             start_i,
    input  logic [WIDTH-1:0] dividend_i,
    input  logic [WIDTH-1:0] divisor_i,
    output logic             done_o,
    output logic [WIDTH-1:0] quotient_o,
    output logic [WIDTH-1:0] remainder_o
);

    localparam int CW = $clog2(WIDTH);
    localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

    logic             run_q;
    logic [CW-1:0]    cnt_q;
    logic [WIDTH-1:0] rem_q, quo_q, dvs_q;
    logic             neg_quo_q, neg_rem_q;
    logic [WIDTH:0]   rem_shift, diff;
    logic [WIDTH-1:0] rem_d, quo_d;
    logic [WIDTH-1:0] a_abs, b_abs;

    // Magnitudes as unsigned WIDTH bits: the most-negative value maps to 2^(WIDTH-1)
    assign a_abs = dividend_i[WIDTH-1] ? ('0 - dividend_i) : dividend_i;
    assign b_abs = divisor_i[WIDTH-1]  ? ('0 - divisor_i)  : divisor_i;

    assign rem_shift = {rem_q, quo_q[WIDTH-1]};
    assign diff      = rem_shift - {1'b0, dvs_q};
    assign rem_d     = diff[WIDTH] ? rem_shift[WIDTH-1:0] : diff[WIDTH-1:0];
    assign quo_d     = {quo_q[WIDTH-2:0], ~diff[WIDTH]};

    // Outputs are taken from the final step so the caller latches them on the same edge
    assign done_o      = run_q && (cnt_q == LAST);
    assign quotient_o  = neg_quo_q ? ('0 - quo_d) : quo_d;
    assign remainder_o = neg_rem_q ? ('0 - rem_d) : rem_d;

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            run_q     <= 1'b0;
            cnt_q     <= '0;
            rem_q     <= '0;
            quo_q     <= '0;
            dvs_q     <= '0;
            neg_quo_q <= 1'b0;
            neg_rem_q <= 1'b0;
        end else if (start_i) begin
            run_q     <= 1'b1;
            cnt_q     <= '0;
            rem_q     <= '0;
            quo_q     <= a_abs;
            dvs_q     <= b_abs;
            neg_quo_q <= dividend_i[WIDTH-1] ^ divisor_i[WIDTH-1];
            neg_rem_q <= dividend_i[WIDTH-1];
        end else if (run_q) begin
            rem_q <= rem_d;
            quo_q <= quo_d;
            cnt_q <= cnt_q + 1'b1;
            if (cnt_q == LAST) begin
                run_q <= 1'b0;
            end
        end
    end

endmodule

// File: rtl/multicycle_alu.sv
// rtl/multicycle_alu.sv - multicycle ALU with Booth multiplier; divider built when MULTICYCLE_ALU_DIV_EN is defined
module multicycle_alu
    import multicycle_alu_pkg::*;
#(
    parameter int WIDTH = 32
) (
    input  logic               clock,
    input  logic               clear_n,
    input  logic               start,
    input  logic [3:0]         opcode,
    input  logic [WIDTH-1:0]   operand_A,
    input  logic [WIDTH-1:0]   operand_B,
    output logic               busy,
    output logic               done,
    output logic [2*WIDTH-1:0] result,
    output logic               div_zero
);

    localparam int SW = $clog2(WIDTH);
    localparam logic [SW-1:0] LAST = SW'(WIDTH - 1);

    state_e             state_q;
    logic               busy_q, done_q, div_zero_q;
    logic [2*WIDTH-1:0] result_q;

    logic [WIDTH:0]     acc_q, mcand_q, acc_sum, acc_d;
    logic [WIDTH-1:0]   mq_q, mq_d;
    logic               qm1_q;
    logic [SW-1:0]      cnt_q;

    logic [SW-1:0]      sh_amt, sh_inv;
    logic [WIDTH-1:0]   alu_lo;

    logic               div_go, div_by0, div_done;
    logic [WIDTH-1:0]   div_quo, div_rem;

    assign sh_amt = operand_B[SW-1:0];
    assign sh_inv = '0 - sh_amt;

    always_comb begin
        alu_lo = '0;
        case (opcode)
            OP_ADD:  alu_lo = operand_A + operand_B;
            OP_SUB:  alu_lo = operand_A - operand_B;
            OP_AND:  alu_lo = operand_A & operand_B;
            OP_OR:   alu_lo = operand_A | operand_B;
            OP_NEG:  alu_lo = '0 - operand_A;
            OP_NOT:  alu_lo = ~operand_A;
            OP_SHR:  alu_lo = operand_A >> sh_amt;
            OP_SHRA: alu_lo = WIDTH'($signed(operand_A) >>> sh_amt);
            OP_SHL:  alu_lo = operand_A << sh_amt;
            // sh_inv is (WIDTH - amt) mod WIDTH, so amt=0 degenerates to A|A
            OP_ROR:  alu_lo = (operand_A >> sh_amt) | (operand_A << sh_inv);
            OP_ROL:  alu_lo = (operand_A << sh_amt) | (operand_A >> sh_inv);
            default: alu_lo = '0;
        endcase
    end

    // One radix-2 Booth step; the extra accumulator bit absorbs +/- most-negative
    always_comb begin
        acc_sum = acc_q;
        case ({mq_q[0], qm1_q})
            2'b01:   acc_sum = acc_q + mcand_q;
            2'b10:   acc_sum = acc_q - mcand_q;
            default: acc_sum = acc_q;
        endcase
    end

    assign acc_d = {acc_sum[WIDTH], acc_sum[WIDTH:1]};
    assign mq_d  = {acc_sum[0], mq_q[WIDTH-1:1]};

`ifdef MULTICYCLE_ALU_DIV_EN
    assign div_by0 = (opcode == OP_DIV) && (operand_B == '0);
    assign div_go  = start && (state_q == ST_IDLE) && (opcode == OP_DIV) && !div_by0;

    seq_divider #(.WIDTH(WIDTH)) u_div (
        .clk_i       (clock),
        .rst_ni      (clear_n),
        .start_i     (div_go),
        .dividend_i  (operand_A),
        .divisor_i   (operand_B),
        .done_o      (div_done),
        .quotient_o  (div_quo),
        .remainder_o (div_rem)
    );
`else
    assign div_by0  = 1'b0;
    assign div_go   = 1'b0;
    assign div_done = 1'b0;
    assign div_quo  = '0;
    assign div_rem  = '0;
`endif

    always_ff @(posedge clock or negedge clear_n) begin
        if (!clear_n) begin
            state_q    <= ST_IDLE;
            busy_q     <= 1'b0;
            done_q     <= 1'b0;
            div_zero_q <= 1'b0;
            result_q   <= '0;
            acc_q      <= '0;
            mcand_q    <= '0;
            mq_q       <= '0;
            qm1_q      <= 1'b0;
            cnt_q      <= '0;
        end else begin
            done_q <= 1'b0;
            case (state_q)
                ST_IDLE: begin
                    if (start) begin
                        busy_q <= 1'b1;
                        if (opcode == OP_MUL) begin
                            state_q <= ST_MUL;
                            acc_q   <= '0;
                            mcand_q <= {operand_A[WIDTH-1], operand_A};
                            mq_q    <= operand_B;
                            qm1_q   <= 1'b0;
                            cnt_q   <= '0;
                        end else if (div_go) begin
                            state_q <= ST_DIV;
                        end else if (div_by0) begin
                            state_q    <= ST_DONE;
                            done_q     <= 1'b1;
                            div_zero_q <= 1'b1;
                            result_q   <= {operand_A, {WIDTH{1'b1}}};
                        end else begin
                            state_q    <= ST_DONE;
                            done_q     <= 1'b1;
                            div_zero_q <= 1'b0;
                            result_q   <= {{WIDTH{1'b0}}, alu_lo};
                        end
                    end
                end
                ST_MUL: begin
                    acc_q <= acc_d;
                    mq_q  <= mq_d;
                    qm1_q <= mq_q[0];
                    cnt_q <= cnt_q + 1'b1;
                    if (cnt_q == LAST) begin
                        state_q    <= ST_DONE;
                        done_q     <= 1'b1;
                        div_zero_q <= 1'b0;
                        result_q   <= {acc_d[WIDTH-1:0], mq_d};
                    end
                end
                ST_DIV: begin
                    if (div_done) begin
                        state_q    <= ST_DONE;
                        done_q     <= 1'b1;
                        div_zero_q <= 1'b0;
                        result_q   <= {div_rem, div_quo};
                    end
                end
                default: begin
                    state_q <= ST_IDLE;
                    busy_q  <= 1'b0;
                end
            endcase
        end
    end

    assign busy     = busy_q;
    assign done     = done_q;
    assign result   = result_q;
    assign div_zero = div_zero_q;

endmodule

// File: tb/tb_multicycle_alu.sv
// tb/tb_multicycle_alu.sv - directed self-checking bench for multicycle_alu (WIDTH=32)
module tb_multicycle_alu;
    import multicycle_alu_pkg::*;

    logic        clock = 1'b0;
    logic        clear_n;
    logic        start;
    logic [3:0]  opcode;
    logic [31:0] operand_A, operand_B;
    logic        busy, done, div_zero;
    logic [63:0] result;

    int n_checks = 0;
    int n_fail   = 0;

    multicycle_alu #(.WIDTH(32)) dut (
        .clock     (clock),
        .clear_n   (clear_n),
        .start     (start),
        .opcode    (opcode),
        .operand_A (operand_A),
        .operand_B (operand_B),
        .busy      (busy),
        .done      (done),
        .result    (result),
        .div_zero  (div_zero)
    );

    always #5 clock = ~clock;

    task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    task automatic launch(input logic [3:0] op, input logic [31:0] a, input logic [31:0] b);
        @(negedge clock);
        start = 1'b1; opcode = op; operand_A = a; operand_B = b;
        @(posedge clock);
        #1;
        start = 1'b0; opcode = 4'h0; operand_A = 32'hDEAD_BEEF; operand_B = 32'h0;
    endtask

    task automatic wait_done(output int lat, output int busy_cycles);
        lat = 0;
        busy_cycles = 0;
        for (int i = 1; i <= 100; i++) begin
            @(negedge clock);
            if (busy) busy_cycles++;
            if (done) begin
                lat = i;
                break;
            end
        end
    endtask

    task automatic do_op(input string tag, input logic [3:0] op, input logic [31:0] a,
                         input logic [31:0] b, input int exp_lat, input logic [63:0] exp_res,
                         input logic exp_dz);
        int lat, bc;
        launch(op, a, b);
        wait_done(lat, bc);
        check_eq({tag, "_lat"}, 64'(lat), 64'(exp_lat));
        check_eq({tag, "_res"}, result, exp_res);
        check_eq({tag, "_dz"}, 64'(div_zero), 64'(exp_dz));
        @(negedge clock);
        check_eq({tag, "_pulse"}, 64'(done), 64'd0);
    endtask

    initial begin
        int lat, bc, n_done;
        clear_n = 1'b0; start = 1'b0; opcode = 4'h0; operand_A = '0; operand_B = '0;
        repeat (3) @(negedge clock);
        check_eq("rst_busy", 64'(busy), 64'd0);
        check_eq("rst_done", 64'(done), 64'd0);
        check_eq("rst_result", result, 64'd0);
        check_eq("rst_dz", 64'(div_zero), 64'd0);
        clear_n = 1'b1;

        do_op("add",  OP_ADD,  32'd7,          32'd5,  1, 64'h0000_0000_0000_000C, 1'b0);
        do_op("sub",  OP_SUB,  32'd5,          32'd7,  1, 64'h0000_0000_FFFF_FFFE, 1'b0);
        do_op("addw", OP_ADD,  32'hFFFF_FFFF,  32'd2,  1, 64'h0000_0000_0000_0001, 1'b0);
        do_op("and",  OP_AND,  32'hF0F0_1234,  32'h0FF0_FF00, 1, 64'h0000_0000_00F0_1200, 1'b0);
        do_op("or",   OP_OR,   32'hF000_0001,  32'h0000_0F00, 1, 64'h0000_0000_F000_0F01, 1'b0);
        do_op("neg",  OP_NEG,  32'd1,          32'd0,  1, 64'h0000_0000_FFFF_FFFF, 1'b0);
        do_op("not",  OP_NOT,  32'h0000_FFFF,  32'd0,  1, 64'h0000_0000_FFFF_0000, 1'b0);
        do_op("shr",  OP_SHR,  32'h8000_0000,  32'd4,  1, 64'h0000_0000_0800_0000, 1'b0);
        do_op("shra", OP_SHRA, 32'h8000_0000,  32'd4,  1, 64'h0000_0000_F800_0000, 1'b0);
        do_op("shl",  OP_SHL,  32'd1,          32'd31, 1, 64'h0000_0000_8000_0000, 1'b0);
        do_op("ror",  OP_ROR,  32'd1,          32'd33, 1, 64'h0000_0000_8000_0000, 1'b0);
        do_op("ror0", OP_ROR,  32'h1234_5678,  32'd32, 1, 64'h0000_0000_1234_5678, 1'b0);
        do_op("rol",  OP_ROL,  32'h8000_0001,  32'd4,  1, 64'h0000_0000_0000_0018, 1'b0);
        do_op("undef", 4'b0000, 32'd9,         32'd3,  1, 64'd0, 1'b0);

        launch(OP_MUL, 32'hFFFF_FFFD, 32'd5);
        wait_done(lat, bc);
        check_eq("mul_lat", 64'(lat), 64'd33);
        check_eq("mul_busy_cycles", 64'(bc), 64'd33);
        check_eq("mul_res", result, 64'hFFFF_FFFF_FFFF_FFF1);
        @(negedge clock);
        check_eq("mul_busy_end", 64'(busy), 64'd0);
        do_op("mulmn", OP_MUL, 32'h8000_0000, 32'h8000_0000, 33, 64'h4000_0000_0000_0000, 1'b0);
        do_op("mul76", OP_MUL, 32'd7, 32'd6, 33, 64'h0000_0000_0000_002A, 1'b0);

`ifdef MULTICYCLE_ALU_DIV_EN
        do_op("div", OP_DIV, 32'hFFFF_FFEF, 32'd5, 33, 64'hFFFF_FFFE_FFFF_FFFD, 1'b0);
        do_op("div_pos", OP_DIV, 32'd100, 32'd7, 33, 64'h0000_0002_0000_000E, 1'b0);
        do_op("div_mn", OP_DIV, 32'h8000_0000, 32'hFFFF_FFFF, 33, 64'h0000_0000_8000_0000, 1'b0);
        do_op("div0", OP_DIV, 32'd9, 32'd0, 1, 64'h0000_0009_FFFF_FFFF, 1'b1);
        repeat (3) @(negedge clock);
        check_eq("div0_hold_dz", 64'(div_zero), 64'd1);
        check_eq("div0_hold_res", result, 64'h0000_0009_FFFF_FFFF);
`else
        do_op("div_off", OP_DIV, 32'd9, 32'd3, 1, 64'd0, 1'b0);
`endif

        // A second start while the multiplier runs must be ignored
        launch(OP_MUL, 32'hFFFF_FFFD, 32'd5);
        lat = 0;
        for (int i = 1; i <= 100; i++) begin
            @(negedge clock);
            if (i == 5) begin
                start = 1'b1; opcode = OP_ADD; operand_A = 32'd7; operand_B = 32'd5;
            end else if (i == 6) begin
                start = 1'b0;
            end
            if (done) begin
                lat = i;
                break;
            end
        end
        start = 1'b0;
        check_eq("mul_ign_lat", 64'(lat), 64'd33);
        check_eq("mul_ign_res", result, 64'hFFFF_FFFF_FFFF_FFF1);
        @(negedge clock);
        check_eq("mul_ign_idle", 64'(busy), 64'd0);

        // Reset in the middle of a multiply
        launch(OP_MUL, 32'd3, 32'd7);
        repeat (10) @(negedge clock);
        clear_n = 1'b0;
        #1;
        check_eq("rstmid_busy", 64'(busy), 64'd0);
        check_eq("rstmid_done", 64'(done), 64'd0);
        check_eq("rstmid_result", result, 64'd0);
        check_eq("rstmid_dz", 64'(div_zero), 64'd0);
        @(negedge clock);
        clear_n = 1'b1;
        n_done = 0;
        for (int i = 0; i < 40; i++) begin
            @(negedge clock);
            if (done) n_done++;
        end
        check_eq("rstmid_no_done", 64'(n_done), 64'd0);
        check_eq("rstmid_idle_result", result, 64'd0);

        // Start on the first edge after reset release
        @(negedge clock);
        clear_n = 1'b0;
        @(negedge clock);
        clear_n = 1'b1;
        start = 1'b1; opcode = OP_ADD; operand_A = 32'd7; operand_B = 32'd5;
        @(posedge clock);
        #1;
        start = 1'b0;
        wait_done(lat, bc);
        check_eq("post_rst_lat", 64'(lat), 64'd1);
        check_eq("post_rst_res", result, 64'h0000_0000_0000_000C);

        repeat (2) @(negedge clock);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
